// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: CPU and DMA request/response channels plus the memory-array side.
// The err signal exists only when DMEM_ARB_RANGE_CHECK_EN is defined.
interface dmem_arbiter_if #(
  parameter int WORD_COUNT = 64
);
  localparam int AW = $clog2(WORD_COUNT);

  logic          cpu_req;
  logic          cpu_we;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_ready;

  logic          dma_req;
  logic          dma_we;
  logic [31:0]   dma_addr;
  logic [31:0]   dma_wdata;
  logic [31:0]   dma_rdata;
  logic          dma_ack;

  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [31:0]   mem_rdata;

`ifdef DMEM_ARB_RANGE_CHECK_EN
  logic          err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ready, dma_rdata, dma_ack,
    output mem_addr, mem_wdata, mem_we, mem_re, err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ready, dma_rdata, dma_ack,
    input  mem_addr, mem_wdata, mem_we, mem_re, err
  );
`else
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ready, dma_rdata, dma_ack,
    output mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ready, dma_rdata, dma_ack,
    input  mem_addr, mem_wdata, mem_we, mem_re
  );
`endif
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin CPU/DMA arbiter for one data-memory port with fixed wait states.
// Optional macro DMEM_ARB_RANGE_CHECK_EN: out-of-window accesses skip memory and return err.

// Per-requester response: read-data holding register and one-cycle ready pulse.
module dmem_arbiter_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic        fire,
  input  logic        load,
  input  logic [31:0] din,
  output logic [31:0] rdata,
  output logic        ready
);
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
      ready <= 1'b0;
    end else begin
      ready <= fire;
      if (load) rdata <= din;
    end
  end
endmodule

module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WORD_COUNT  = 64,
  parameter int          WAIT_CYCLES = 2
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  localparam int          NUM_REQ = 2;   // lane 0 = CPU, lane 1 = DMA
  localparam int          AW      = $clog2(WORD_COUNT);
  localparam logic [31:0] SPAN    = 32'(4 * WORD_COUNT);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t                       state;
  logic [3:0]                   cnt;
  logic                         last;
  logic                         win;
  logic                         we_q;
  logic                         pend;
  logic [AW-1:0]                mem_addr;
  logic [31:0]                  mem_wdata;
  logic                         mem_we;
  logic                         mem_re;

  logic [NUM_REQ-1:0]           req;
  req_t [NUM_REQ-1:0]           cand;
  req_t                         sel;
  logic                         gnt;
  logic [31:0]                  off;
  logic                         unused_bits;

  logic [NUM_REQ-1:0]           fire;
  logic [NUM_REQ-1:0]           load;
  logic [NUM_REQ-1:0][31:0]     rdata;
  logic [NUM_REQ-1:0]           ready;
  logic [31:0]                  din;

  assign req     = {bus.dma_req, bus.cpu_req};
  assign cand[0] = {bus.cpu_we, bus.cpu_addr, bus.cpu_wdata};
  assign cand[1] = {bus.dma_we, bus.dma_addr, bus.dma_wdata};

  // On a tie the requester that did not win last time goes next.
  assign gnt = (&req) ? ~last : req[1];
  assign sel = cand[gnt];

  // Unsigned wrap makes addresses below the base land far above SPAN.
  assign off         = sel.addr - BASE_ADDR;
  assign unused_bits = ^{off[31:AW+2], off[1:0]};

`ifdef DMEM_ARB_RANGE_CHECK_EN
  logic oor;
  logic err_q;

  assign oor = (off >= SPAN);

  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= (state == DONE) && pend;
  end

  assign bus.err = err_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      win       <= 1'b0;
      we_q      <= 1'b0;
      pend      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            win       <= gnt;
            last      <= gnt;
            we_q      <= sel.we;
            cnt       <= 4'(WAIT_CYCLES);
            mem_addr  <= off[AW+1:2];
            mem_wdata <= sel.wdata;
`ifdef DMEM_ARB_RANGE_CHECK_EN
            if (oor) begin
              state <= DONE;
              pend  <= 1'b1;
            end else
`endif
            begin
              state  <= ACCESS;
              mem_we <= sel.we;
              mem_re <= ~sel.we;
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state  <= DONE;
            mem_we <= 1'b0;
            mem_re <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          // A skipped access spends one quiet DONE cycle before its pulse.
          if (pend) pend  <= 1'b0;
          else      state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion is decided one cycle early so ready/rdata are registered.
  always_comb begin
    fire = '0;
    load = '0;
    if ((state == ACCESS && cnt == '0) || (state == DONE && pend)) begin
      fire[win] = 1'b1;
      load[win] = pend | ~we_q;
    end
  end

  assign din = pend ? 32'h0 : bus.mem_rdata;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    dmem_arbiter_lane u_lane (
      .clk   (clk),
      .rst   (rst),
      .fire  (fire[i]),
      .load  (load[i]),
      .din   (din),
      .rdata (rdata[i]),
      .ready (ready[i])
    );
  end

  assign bus.cpu_rdata = rdata[0];
  assign bus.cpu_ready = ready[0];
  assign bus.dma_rdata = rdata[1];
  assign bus.dma_ack   = ready[1];
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_we    = mem_we;
  assign bus.mem_re    = mem_re;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: word-array memory, transaction-level reference model,
// directed scenarios plus randomized single and back-to-back traffic.
module tb_dmem_arbiter;
  localparam logic [31:0] BASE = 32'd1024;
  localparam int          WC   = 64;
  localparam int          W    = 2;
  localparam int          AW   = $clog2(WC);

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  dmem_arbiter_if #(.WORD_COUNT(WC)) bus();

  dmem_arbiter #(.BASE_ADDR(BASE), .WORD_COUNT(WC), .WAIT_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory array driven by the DUT, plus a preload port used under reset.
  logic [31:0]   mem [WC];
  logic [31:0]   ref_mem [WC];
  logic          pl = 1'b0;
  logic [AW-1:0] pl_idx = '0;
  logic [31:0]   pl_data = '0;
  bit            model_last;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (pl)              mem[pl_idx] <= pl_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] model_idx(input logic [31:0] a);
    logic [31:0] d;
    d = a - BASE;
    return AW'((d / 32'd4) % WC);
  endfunction

  function automatic logic [31:0] rand_addr();
`ifdef DMEM_ARB_RANGE_CHECK_EN
    return BASE + 32'(4 * $urandom_range(0, WC - 1)) + 32'($urandom_range(0, 3));
`else
    return 32'($urandom_range(0, 4095));
`endif
  endfunction

  // Drives one request to completion; returns what was observed.
  task automatic run_one(input bit dma, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rd, output int we_n, output int re_n,
                         output logic [AW-1:0] idx, output bit err_seen);
    lat = 0; rd = '0; we_n = 0; re_n = 0; idx = '0; err_seen = 1'b0;
    if (dma) begin
      bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 1) begin
        // Inputs are latched at grant; disturb them to prove it.
        if (dma) begin bus.dma_we = ~we; bus.dma_addr = $urandom; bus.dma_wdata = $urandom; end
        else     begin bus.cpu_we = ~we; bus.cpu_addr = $urandom; bus.cpu_wdata = $urandom; end
      end
      if (bus.mem_we) we_n++;
      if (bus.mem_re) re_n++;
      if (bus.mem_we || bus.mem_re) idx = bus.mem_addr;
      if (dma ? bus.dma_ack : bus.cpu_ready) begin
        lat = i;
        rd  = dma ? bus.dma_rdata : bus.cpu_rdata;
`ifdef DMEM_ARB_RANGE_CHECK_EN
        err_seen = bus.err;
`endif
        break;
      end
    end
    if (dma) bus.dma_req = 1'b0;
    else     bus.cpu_req = 1'b0;
    tick();
  endtask

  task automatic run_tie(input string tag, input logic [31:0] ca, input logic [31:0] da);
    int tc = 0;
    int td = 0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = ca;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = da;
    for (int i = 1; i <= 40 && (tc == 0 || td == 0); i++) begin
      tick();
      if (bus.cpu_ready && tc == 0) begin
        tc = i;
        bus.cpu_req = 1'b0;
        vectors++;
        if (bus.cpu_rdata !== ref_mem[model_idx(ca)]) begin
          errors++; $display("FAIL %s_cpu_rdata: got %h want %h", tag, bus.cpu_rdata, ref_mem[model_idx(ca)]);
        end
      end
      if (bus.dma_ack && td == 0) begin
        td = i;
        bus.dma_req = 1'b0;
        vectors++;
        if (bus.dma_rdata !== ref_mem[model_idx(da)]) begin
          errors++; $display("FAIL %s_dma_rdata: got %h want %h", tag, bus.dma_rdata, ref_mem[model_idx(da)]);
        end
      end
    end
    vectors++;
    if (tc != W + 2) begin errors++; $display("FAIL %s_cpu_first: cpu_ready at %0d want %0d", tag, tc, W + 2); end
    vectors++;
    if (td != W + 2 + W + 3) begin errors++; $display("FAIL %s_dma_next: dma_ack at %0d want %0d", tag, td, 2 * W + 5); end
    model_last = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    pl = 1'b1;
    for (int i = 0; i < WC; i++) begin
      pl_idx = AW'(i); pl_data = $urandom; ref_mem[i] = pl_data;
      tick();
    end
    pl = 1'b0;
    tick();
    vectors++;
    if ({bus.cpu_ready, bus.dma_ack} !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", {bus.cpu_ready, bus.dma_ack}); end
    vectors++;
    if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_cpu_rdata: got %h want 0", bus.cpu_rdata); end
    vectors++;
    if (bus.dma_rdata !== 32'h0) begin errors++; $display("FAIL rst_dma_rdata: got %h want 0", bus.dma_rdata); end
    vectors++;
    if ({bus.mem_we, bus.mem_re} !== 2'b00) begin errors++; $display("FAIL rst_mem_strobes: got %b want 00", {bus.mem_we, bus.mem_re}); end
    vectors++;
    if (bus.mem_addr !== '0 || bus.mem_wdata !== 32'h0) begin
      errors++; $display("FAIL rst_mem_bus: got addr %h data %h want 0 0", bus.mem_addr, bus.mem_wdata);
    end
    rst = 1'b1;
    model_last = 1'b1;
    tick();
  endtask

  task automatic test_tie();
    run_tie("tie", BASE + 32'd8, BASE + 32'd12);
  endtask

  task automatic test_write_read();
    int lat, wn, rn; logic [31:0] rd; logic [AW-1:0] idx; bit e;
    run_one(1'b0, 1'b1, 32'h404, 32'hDEADBEEF, lat, rd, wn, rn, idx, e);
    model_last = 1'b0;
    ref_mem[1] = 32'hDEADBEEF;
    vectors++; if (lat != W + 2) begin errors++; $display("FAIL wr_latency: got %0d want %0d", lat, W + 2); end
    vectors++; if (wn != W + 1) begin errors++; $display("FAIL wr_we_cycles: got %0d want %0d", wn, W + 1); end
    vectors++; if (idx !== AW'(1)) begin errors++; $display("FAIL wr_mem_addr: got %0d want 1", idx); end
    vectors++; if (rn != 0) begin errors++; $display("FAIL wr_no_re: got %0d want 0", rn); end
    run_one(1'b0, 1'b0, 32'h404, $urandom, lat, rd, wn, rn, idx, e);
    vectors++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    vectors++; if (lat != W + 2) begin errors++; $display("FAIL rd_latency: got %0d want %0d", lat, W + 2); end
    vectors++; if (wn != 0) begin errors++; $display("FAIL rd_no_we: got %0d want 0", wn); end
    vectors++; if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL ready_pulse: got %b want 0", bus.cpu_ready); end
    vectors++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold: got %h want deadbeef", bus.cpu_rdata); end
    run_one(1'b0, 1'b0, 32'h407, $urandom, lat, rd, wn, rn, idx, e);
    vectors++; if (rd !== 32'hDEADBEEF || idx !== AW'(1)) begin
      errors++; $display("FAIL low_bits: got %h @%0d want deadbeef @1", rd, idx);
    end
    // DMA and CPU-write traffic must not disturb the held CPU read data.
    run_one(1'b1, 1'b1, BASE + 32'd20, 32'h1234_5678, lat, rd, wn, rn, idx, e);
    ref_mem[5] = 32'h1234_5678;
    run_one(1'b1, 1'b0, BASE + 32'd20, $urandom, lat, rd, wn, rn, idx, e);
    vectors++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL dma_rd: got %h want 12345678", rd); end
    run_one(1'b0, 1'b1, BASE + 32'd24, 32'hCAFE_F00D, lat, rd, wn, rn, idx, e);
    ref_mem[6] = 32'hCAFE_F00D;
    model_last = 1'b0;
    vectors++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_untouched: got %h want deadbeef", bus.cpu_rdata); end
  endtask

  task automatic test_window();
    int lat, wn, rn; logic [31:0] rd, wd; logic [AW-1:0] idx; bit e;
    wd = $urandom;
`ifdef DMEM_ARB_RANGE_CHECK_EN
    run_one(1'b0, 1'b0, 32'h3FC, $urandom, lat, rd, wn, rn, idx, e);
    vectors++; if (lat != 2) begin errors++; $display("FAIL oor_latency: got %0d want 2", lat); end
    vectors++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rdata: got %h want 0", rd); end
    vectors++; if (e !== 1'b1) begin errors++; $display("FAIL oor_err: got %b want 1", e); end
    vectors++; if (rn != 0 || wn != 0) begin errors++; $display("FAIL oor_strobes: got re %0d we %0d want 0 0", rn, wn); end
    run_one(1'b1, 1'b1, 32'h500, wd, lat, rd, wn, rn, idx, e);
    vectors++; if (wn != 0 || e !== 1'b1) begin errors++; $display("FAIL oor_write: got we %0d err %b want 0 1", wn, e); end
    model_last = 1'b1;
`else
    run_one(1'b0, 1'b1, 32'h3FC, wd, lat, rd, wn, rn, idx, e);
    ref_mem[model_idx(32'h3FC)] = wd;
    vectors++; if (idx !== AW'(WC - 1)) begin errors++; $display("FAIL below_base_idx: got %0d want %0d", idx, WC - 1); end
    run_one(1'b1, 1'b0, BASE + 32'(4 * (WC - 1)), $urandom, lat, rd, wn, rn, idx, e);
    vectors++; if (rd !== wd) begin errors++; $display("FAIL below_base_alias: got %h want %h", rd, wd); end
    run_one(1'b0, 1'b0, 32'h500, $urandom, lat, rd, wn, rn, idx, e);
    model_last = 1'b0;
    vectors++; if (idx !== '0 || rd !== ref_mem[0]) begin
      errors++; $display("FAIL wrap_alias: got %h @%0d want %h @0", rd, idx, ref_mem[0]);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [2];
    logic [31:0] d [2];
    bit          w [2];
    int issued = 2, done_n = 0, last_t = 0;
    bit idle_chk = 1'b0, who;
    logic [31:0] got;
    for (int r = 0; r < 2; r++) begin a[r] = rand_addr(); d[r] = $urandom; w[r] = 1'($urandom); end
    bus.cpu_req = 1'b1; bus.cpu_we = w[0]; bus.cpu_addr = a[0]; bus.cpu_wdata = d[0];
    bus.dma_req = 1'b1; bus.dma_we = w[1]; bus.dma_addr = a[1]; bus.dma_wdata = d[1];
    for (int t = 1; t <= 300 && done_n < 8; t++) begin
      tick();
      if (idle_chk) begin
        idle_chk = 1'b0;
        vectors++;
        if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL b2b_idle_we: got %b want 0", bus.mem_we); end
      end
      if (bus.cpu_ready || bus.dma_ack) begin
        who = bus.dma_ack;
        vectors++;
        // Both stay pending until the last pair, so grants alternate.
        if (who !== ~model_last || (bus.cpu_ready && bus.dma_ack)) begin
          errors++; $display("FAIL b2b_order: got dma=%b both=%b want dma=%b", who, bus.cpu_ready && bus.dma_ack, ~model_last);
        end
        model_last = who;
        vectors++;
        if ({bus.mem_we, bus.mem_re} !== 2'b00) begin errors++; $display("FAIL b2b_done_quiet: got %b want 00", {bus.mem_we, bus.mem_re}); end
        if (done_n > 0) begin
          vectors++;
          if (t - last_t != W + 3) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", t - last_t, W + 3); end
        end
        last_t = t;
        if (w[who]) begin
          ref_mem[model_idx(a[who])] = d[who];
        end else begin
          got = who ? bus.dma_rdata : bus.cpu_rdata;
          vectors++;
          if (got !== ref_mem[model_idx(a[who])]) begin
            errors++; $display("FAIL b2b_rdata: got %h want %h", got, ref_mem[model_idx(a[who])]);
          end
        end
        done_n++;
        idle_chk = 1'b1;
        if (issued < 8) begin
          issued++;
          a[who] = rand_addr(); d[who] = $urandom; w[who] = 1'($urandom);
          if (who) begin bus.dma_we = w[1]; bus.dma_addr = a[1]; bus.dma_wdata = d[1]; end
          else     begin bus.cpu_we = w[0]; bus.cpu_addr = a[0]; bus.cpu_wdata = d[0]; end
        end else begin
          if (who) bus.dma_req = 1'b0;
          else     bus.cpu_req = 1'b0;
        end
      end
    end
    vectors++;
    if (done_n != 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", done_n); end
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] wd; logic [AW-1:0] k; int acks = 0, wes = 0;
    wd = $urandom; k = AW'($urandom_range(0, WC - 1));
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = BASE + 32'({k, 2'b00}); bus.dma_wdata = wd;
    tick();
    tick();
    rst = 1'b0; bus.dma_req = 1'b0;
    tick();
    vectors++;
    if ({bus.dma_ack, bus.cpu_ready, bus.mem_we, bus.mem_re} !== 4'b0) begin
      errors++; $display("FAIL mid_rst_ctrl: got %b want 0000", {bus.dma_ack, bus.cpu_ready, bus.mem_we, bus.mem_re});
    end
    vectors++;
    if ({bus.cpu_rdata, bus.dma_rdata, bus.mem_wdata} !== 96'h0 || bus.mem_addr !== '0) begin
      errors++; $display("FAIL mid_rst_data: got %h %h %h @%0d want zeros", bus.cpu_rdata, bus.dma_rdata, bus.mem_wdata, bus.mem_addr);
    end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.dma_ack) acks++;
      if (bus.mem_we) wes++;
    end
    vectors++;
    if (acks != 0 || wes != 0) begin errors++; $display("FAIL mid_rst_abort: got ack %0d we %0d want 0 0", acks, wes); end
    // Two ACCESS cycles of the aborted write already strobed the array.
    ref_mem[k] = wd;
    model_last = 1'b1;
    run_tie("post_rst", BASE + 32'({k, 2'b00}), BASE + 32'(4 * $urandom_range(0, WC - 1)));
  endtask

  task automatic test_random();
    int lat, wn, rn; logic [31:0] rd, a, wd, other; logic [AW-1:0] idx; bit e, dma, we;
    for (int n = 0; n < 24; n++) begin
      dma = 1'($urandom); we = 1'($urandom); a = rand_addr(); wd = $urandom;
      other = dma ? bus.cpu_rdata : bus.dma_rdata;
      run_one(dma, we, a, wd, lat, rd, wn, rn, idx, e);
      model_last = dma;
      vectors++;
      if (lat != W + 2) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", n, lat, W + 2); end
      vectors++;
      if (idx !== model_idx(a)) begin errors++; $display("FAIL rnd_idx[%0d]: got %0d want %0d", n, idx, model_idx(a)); end
      vectors++;
      if ((dma ? bus.cpu_rdata : bus.dma_rdata) !== other) begin
        errors++; $display("FAIL rnd_other_rdata[%0d]: got %h want %h", n, dma ? bus.cpu_rdata : bus.dma_rdata, other);
      end
      if (we) begin
        ref_mem[model_idx(a)] = wd;
        vectors++;
        if (wn != W + 1 || rn != 0) begin errors++; $display("FAIL rnd_wr_strobes[%0d]: got we %0d re %0d want %0d 0", n, wn, rn, W + 1); end
      end else begin
        vectors++;
        if (rd !== ref_mem[model_idx(a)]) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, rd, ref_mem[model_idx(a)]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_write_read();
    test_window();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
